// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell is reused WIDTH times,
// processing the operands LSB-first, one bit per clock, behind a
// start/busy/done handshake.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iNum1,
    input  logic [WIDTH-1:0] iNum2,
    input  logic             iCin,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oSum,
    output logic             oCout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT            state;
    stateT            nextState;

    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic [CW-1:0]    bitCount;

    logic             sumBit;
    logic             carryOut;
    logic             lastBit;
    logic             loadOps;
    logic             shiftEn;

    // The single full-adder cell, fed from the operand LSBs and the carry register
    assign sumBit   = opA[0] ^ opB[0] ^ carry;
    assign carryOut = (opA[0] & opB[0]) | (opB[0] & carry) | (opA[0] & carry);
    assign lastBit  = (bitCount == CW'(WIDTH - 1));

    // Handshake outputs decode directly from the state register
    assign oBusy = (state == RUN) || (state == DONE);
    assign oDone = (state == DONE);

    // State register; reset aborts any operation in progress
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic and datapath control strobes
    always_comb begin
        nextState = state;
        loadOps   = 1'b0;
        shiftEn   = 1'b0;
        case (state)
            IDLE: begin
                if (iStart) begin
                    loadOps   = 1'b1;
                    nextState = RUN;
                end
            end
            RUN: begin
                shiftEn = 1'b1;
                if (lastBit) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Operand/result shifters, carry and bit counter; the result outputs are
    // loaded on the edge that processes the last bit so they line up with oDone
    always_ff @(posedge iClk) begin
        if (iRst) begin
            opA      <= '0;
            opB      <= '0;
            result   <= '0;
            carry    <= 1'b0;
            bitCount <= '0;
            oSum     <= '0;
            oCout    <= 1'b0;
        end else if (loadOps) begin
            opA      <= iNum1;
            opB      <= iNum2;
            carry    <= iCin;
            bitCount <= '0;
        end else if (shiftEn) begin
            opA      <= {1'b0, opA[WIDTH-1:1]};
            opB      <= {1'b0, opB[WIDTH-1:1]};
            result   <= {sumBit, result[WIDTH-1:1]};
            carry    <= carryOut;
            bitCount <= bitCount + CW'(1);
            if (lastBit) begin
                oSum  <= {sumBit, result[WIDTH-1:1]};
                oCout <= carryOut;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=16, compared
// against plain A+B+Cin arithmetic and the handshake timing rules.
module tb_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst;

    logic        start8;
    logic [7:0]  num1a;
    logic [7:0]  num2a;
    logic        cin8;
    logic        busy8;
    logic        done8;
    logic [7:0]  sum8;
    logic        cout8;

    logic        start16;
    logic [15:0] num1b;
    logic [15:0] num2b;
    logic        cin16;
    logic        busy16;
    logic        done16;
    logic [15:0] sum16;
    logic        cout16;

    int checks   = 0;
    int failures = 0;

    // Free-running clock
    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .iClk(clk), .iRst(rst), .iStart(start8),
        .iNum1(num1a), .iNum2(num2a), .iCin(cin8),
        .oBusy(busy8), .oDone(done8), .oSum(sum8), .oCout(cout8)
    );

    serial_add_ctrl #(.WIDTH(16)) dut16 (
        .iClk(clk), .iRst(rst), .iStart(start16),
        .iNum1(num1b), .iNum2(num2b), .iCin(cin16),
        .oBusy(busy16), .oDone(done16), .oSum(sum16), .oCout(cout16)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive the inputs of one of the two instances
    task automatic applyStimulus(input bit wide, input logic [31:0] a, input logic [31:0] b,
                                 input logic c, input logic st);
        if (wide) begin
            num1b   = a[15:0];
            num2b   = b[15:0];
            cin16   = c;
            start16 = st;
        end else begin
            num1a  = a[7:0];
            num2a  = b[7:0];
            cin8   = c;
            start8 = st;
        end
    endtask

    // One full operation: start pulse, then watch WIDTH+3 cycles counting busy
    // and done, scrambling operands (or re-pulsing start) along the way
    task automatic runOp(input bit wide, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input bit inject, input string tag);
        int          w;
        logic [32:0] total;
        logic [32:0] mask;
        int          busyCnt;
        int          doneCnt;
        int          doneAt;
        logic [31:0] gotSum;
        logic        gotCout;
        logic        curBusy;
        logic        curDone;
        logic        st;
        w       = wide ? 16 : 8;
        total   = {1'b0, a} + {1'b0, b} + 33'(c);
        mask    = (33'd1 << w) - 33'd1;
        busyCnt = 0;
        doneCnt = 0;
        doneAt  = 0;
        gotSum  = '0;
        gotCout = 1'b0;
        @(negedge clk);
        applyStimulus(wide, a, b, c, 1'b1);
        for (int k = 1; k <= w + 3; k++) begin
            @(negedge clk);
            curBusy = wide ? busy16 : busy8;
            curDone = wide ? done16 : done8;
            if (curBusy) busyCnt++;
            if (curDone) begin
                doneCnt++;
                doneAt  = k;
                gotSum  = wide ? {16'd0, sum16} : {24'd0, sum8};
                gotCout = wide ? cout16 : cout8;
            end
            st = inject && (k == 3 || k == w + 1);
            if (inject) applyStimulus(wide, 32'hAAAA, 32'hAAAA, 1'b1, st);
            else        applyStimulus(wide, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
        end
        applyStimulus(wide, 32'd0, 32'd0, 1'b0, 1'b0);
        checkOutput({tag, ".doneCount"}, 33'(doneCnt), 33'd1);
        checkOutput({tag, ".doneCycle"}, 33'(doneAt), 33'(w + 1));
        checkOutput({tag, ".busyCycles"}, 33'(busyCnt), 33'(w + 1));
        checkOutput({tag, ".sum"}, {1'b0, gotSum}, total & mask);
        checkOutput({tag, ".cout"}, 33'(gotCout), 33'(total[w]));
    endtask

    int          bbDoneAt[$];
    logic [8:0]  bbResult[$];
    int          lateDone;

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("reset.busy8", 33'(busy8), 33'd0);
        checkOutput("reset.done8", 33'(done8), 33'd0);
        checkOutput("reset.sum8", {cout8, 24'd0, sum8}, 33'd0);
        checkOutput("reset.sum16", {cout16, 16'd0, sum16}, 33'd0);
        checkOutput("reset.busy16", 33'({busy16, done16}), 33'd0);
        rst = 1'b0;

        runOp(1'b0, 32'h5A, 32'h3C, 1'b0, 1'b0, "basic5A3C");

        // Abort in the fourth RUN cycle; outputs clear, no done follows
        @(negedge clk);
        applyStimulus(1'b0, 32'h77, 32'h11, 1'b1, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            applyStimulus(1'b0, 32'h77, 32'h11, 1'b1, 1'b0);
        end
        checkOutput("abort.busyBefore", 33'(busy8), 33'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort.busy", 33'(busy8), 33'd0);
        checkOutput("abort.sum", 33'(sum8), 33'd0);
        checkOutput("abort.cout", 33'(cout8), 33'd0);
        lateDone = 0;
        for (int k = 0; k < 12; k++) begin
            if (done8 || busy8) lateDone++;
            @(negedge clk);
        end
        checkOutput("abort.noDone", 33'(lateDone), 33'd0);

        runOp(1'b0, 32'hFF, 32'h01, 1'b0, 1'b0, "rippleFF01");
        runOp(1'b0, 32'hFF, 32'hFF, 1'b1, 1'b0, "allOnes");
        runOp(1'b0, 32'h01, 32'h02, 1'b0, 1'b0, "majority0102");
        runOp(1'b0, 32'h10, 32'h20, 1'b0, 1'b1, "startIgnored");

        // Back-to-back with start held high
        @(negedge clk);
        applyStimulus(1'b0, 32'd3, 32'd4, 1'b0, 1'b1);
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            if (k == 1) applyStimulus(1'b0, 32'h80, 32'h80, 1'b0, 1'b1);
            if (done8) begin
                bbDoneAt.push_back(k);
                bbResult.push_back({cout8, sum8});
                if (bbDoneAt.size() >= 2) applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
            end
        end
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("b2b.doneCount", 33'(bbDoneAt.size()), 33'd2);
        if (bbDoneAt.size() >= 2) begin
            checkOutput("b2b.firstAt", 33'(bbDoneAt[0]), 33'd9);
            checkOutput("b2b.spacing", 33'(bbDoneAt[1] - bbDoneAt[0]), 33'd10);
            checkOutput("b2b.first", 33'(bbResult[0]), 33'(9'd3 + 9'd4));
            checkOutput("b2b.second", 33'(bbResult[1]), 33'(9'h80 + 9'h80));
        end

        for (int i = 0; i < 1000; i++) begin
            runOp(1'b0, 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'b0, "rand8");
        end
        for (int i = 0; i < 1000; i++) begin
            runOp(1'b1, 32'($urandom_range(0, 65535)), 32'($urandom_range(0, 65535)),
                  1'($urandom_range(0, 1)), 1'b0, "rand16");
        end
        runOp(1'b1, 32'hFFFF, 32'h0000, 1'b1, 1'b0, "ripple16");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
